// File: rtl/ecc_secded_decoder_pipe.sv
// ecc_secded_decoder_pipe
//   Two-stage pipelined SECDED decoder (Hamming code plus an overall parity bit)
//   with valid/ready flow control and saturating error counters. It sits on the
//   cache read-data path, directly after the SRAM.
//
//   Codeword positions run 1..N with N = DATA_W+CODE_W-1. Hamming bit in_code[i]
//   sits at position 2^i. Data bits fill the remaining positions in ascending
//   order, starting with in_data[0]. in_code[CODE_W-1] is even parity over all
//   data and Hamming bits.
//
//   Stage 1 registers the syndrome, the overall check and the raw data.
//   Stage 2 classifies the word and corrects it.
//
// Parameters
//   DATA_W  data width (>= 4)
//   CODE_W  check bits (CODE_W-1 Hamming bits + 1 overall parity bit)
//   CNT_W   width of each saturating error counter
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   in_data/in_code      received word and check bits
//   in_vld/in_rdy        input handshake
//   out_data             corrected data (raw data when uncorrectable)
//   out_corr/out_uncorr  single-bit error corrected / uncorrectable error
//   out_vld/out_rdy      output handshake
//   cnt_clr              clears both counters; wins over a same-cycle increment
//   corr_cnt/uncorr_cnt  saturating counts of accepted corrected/uncorrectable words
//
// Configuration
//   ECC_DEC_ERR_INJECT_EN  adds the inj_en/inj_mask ports. When inj_en is high,
//                          {in_code,in_data} is XORed with inj_mask on the
//                          accepted beat.
module ecc_secded_decoder_pipe #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef ECC_DEC_ERR_INJECT_EN
  input  logic                     inj_en,
  input  logic [DATA_W+CODE_W-1:0] inj_mask,
`endif
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CODE_W-1:0]        in_code,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_corr,
  output logic                     out_uncorr,
  output logic                     out_vld,
  input  logic                     out_rdy,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         corr_cnt,
  output logic [CNT_W-1:0]         uncorr_cnt
);

  localparam int SYN_W = CODE_W - 1;
  localparam int N     = DATA_W + CODE_W - 1;

  // Codeword position of data bit j: the j-th position that is not a power of two.
  function automatic int data_pos(input int j);
    int cnt;
    data_pos = 0;
    cnt      = 0;
    for (int p = 3; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) data_pos = p;
        cnt++;
      end
    end
  endfunction

  logic [SYN_W-1:0] pos_tbl [DATA_W];
  for (genvar j = 0; j < DATA_W; j++) begin : g_pos
    assign pos_tbl[j] = SYN_W'(data_pos(j));
  end

  logic adv;
  assign adv    = !out_vld || out_rdy;
  // Reset also forces ready high, so a stalled pipe never blocks the input while in reset.
  assign in_rdy = adv || reset;

  // ---------------- stage 1: syndrome ----------------
  logic [DATA_W+CODE_W-1:0] rx;
`ifdef ECC_DEC_ERR_INJECT_EN
  assign rx = {in_code, in_data} ^ (inj_en ? inj_mask : '0);
`else
  assign rx = {in_code, in_data};
`endif

  // The syndrome is the XOR of the positions of all set bits.
  // A Hamming bit at position 2^i contributes only syndrome bit i.
  logic [SYN_W-1:0] syn_d;
  always_comb begin
    // NOTE: assign a default before the loops so the combinational block can never infer a latch.
    syn_d = '0;
    for (int j = 0; j < DATA_W; j++)
      if (rx[j]) syn_d = syn_d ^ pos_tbl[j];
    for (int i = 0; i < SYN_W; i++)
      if (rx[DATA_W+i]) syn_d[i] = ~syn_d[i];
  end

  logic              s1_vld;
  logic [SYN_W-1:0]  s1_syn;
  logic              s1_ovr;
  logic [DATA_W-1:0] s1_data;

  // NOTE: the stage-1 payload is not reset; s1_vld qualifies it, so reset only needs the control bit.
  always_ff @(posedge clk) begin
    if (adv && in_vld) begin
      s1_syn  <= syn_d;
      s1_ovr  <= ^rx;
      s1_data <= rx[DATA_W-1:0];
    end
  end

  // ---------------- stage 2: classify and correct ----------------
  logic              syn_nz, in_range, single, uncorr;
  logic [DATA_W-1:0] flip_mask;

  assign syn_nz   = |s1_syn;
  assign in_range = s1_syn <= SYN_W'(N);
  // Overall check set with the syndrome in range: single error. This covers
  // syndrome zero, which means the overall parity bit itself flipped.
  assign single   = s1_ovr && (!syn_nz || in_range);
  assign uncorr   = (syn_nz && !s1_ovr) || (s1_ovr && !in_range);

  always_comb begin
    flip_mask = '0;
    for (int j = 0; j < DATA_W; j++)
      flip_mask[j] = s1_ovr && (pos_tbl[j] == s1_syn);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (adv) begin
      // NOTE: sequential state uses non-blocking assignments so that both stages shift on the same edge.
      s1_vld     <= in_vld;
      out_vld    <= s1_vld;
      out_data   <= s1_vld ? (s1_data ^ flip_mask) : '0;
      out_corr   <= s1_vld && single;
      out_uncorr <= s1_vld && uncorr;
    end
  end

  // ---------------- saturating error counters ----------------
  logic fire;
  assign fire = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (fire) begin
      if (out_corr && corr_cnt != '1)     corr_cnt   <= corr_cnt + CNT_W'(1);
      if (out_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ecc_secded_decoder_pipe.sv
// tb_ecc_secded_decoder_pipe
//   Scoreboard bench for ecc_secded_decoder_pipe (DATA_W=32, CODE_W=7, CNT_W=4).
//   The bench encodes each word itself and then flips 0, 1 or 2 chosen bits.
//   The expected result follows from the number of flips alone:
//     0 flips: clean word, original data.
//     1 flip:  corrected, original data.
//     2 flips: uncorrectable, raw received data.
//   A monitor pops expectations on every output handshake. It also tracks the
//   counters and checks that outputs hold during stalls.
module tb_ecc_secded_decoder_pipe;
  localparam int DATA_W = 32;
  localparam int CODE_W = 7;
  localparam int CNT_W  = 4;
  localparam int TOT    = DATA_W + CODE_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic [CODE_W-1:0] in_code = '0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [DATA_W-1:0] out_data;
  logic              out_corr, out_uncorr, out_vld;
  logic              out_rdy = 1'b0;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;
  logic              inj_en = 1'b0;
  logic [TOT-1:0]    inj_mask = '0;

  ecc_secded_decoder_pipe #(.DATA_W(DATA_W), .CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
`ifdef ECC_DEC_ERR_INJECT_EN
    .inj_en(inj_en), .inj_mask(inj_mask),
`endif
    .in_data(in_data), .in_code(in_code), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_corr(out_corr), .out_uncorr(out_uncorr),
    .out_vld(out_vld), .out_rdy(out_rdy), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              uncorr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   bp_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference encoder. Hamming bit i is the parity of all data bits whose
  // position has bit i set. The top check bit is the overall even parity.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p < TOT; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < CODE_W - 1; i++)
          if (((p >> i) & 1) == 1 && d[j]) c[i] = ~c[i];
        j++;
      end
    end
    c[CODE_W-1] = ^{c[CODE_W-2:0], d};
    return c;
  endfunction

  function automatic logic [TOT-1:0] rand_flip(input int k);
    logic [TOT-1:0] m;
    int b1, b2;
    m  = '0;
    b1 = $urandom_range(TOT - 1);
    b2 = b1;
    while (b2 == b1) b2 = $urandom_range(TOT - 1);
    if (k >= 1) m[b1] = 1'b1;
    if (k >= 2) m[b2] = 1'b1;
    return m;
  endfunction

  // Presents one word and waits (bounded) for acceptance. The expectation is
  // queued just before the accepting edge.
  task automatic send_raw(input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] c,
                          input exp_t e, input logic [TOT-1:0] inj);
    int waited;
    in_data  = d;
    in_code  = c;
    in_vld   = 1'b1;
    inj_mask = inj;
    inj_en   = |inj;
    waited   = 0;
    @(negedge clk);
    while (!in_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("send_accept", in_rdy, 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_vld   = 1'b0;
    inj_en   = 1'b0;
    inj_mask = '0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [TOT-1:0] flip,
                      input logic [TOT-1:0] inj);
    logic [TOT-1:0] raw, eff, seen;
    exp_t e;
    int nerr;
    raw = {encode(d), d} ^ flip;
`ifdef ECC_DEC_ERR_INJECT_EN
    eff = flip ^ inj;
`else
    eff = flip;
`endif
    seen     = {encode(d), d} ^ eff;
    nerr     = $countones(eff);
    e.corr   = (nerr == 1);
    e.uncorr = (nerr == 2);
    e.data   = (nerr == 2) ? seen[DATA_W-1:0] : d;
    send_raw(raw[DATA_W-1:0], raw[TOT-1:DATA_W], e, inj);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the scoreboard, the counter model and the stall-hold check.
  exp_t              mon_e;
  int                m_corr = 0, m_uncorr = 0;
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] p_data;
  logic              p_corr, p_uncorr;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_corr     = 0;
      m_uncorr   = 0;
      stall_prev = 1'b0;
    end else begin
      logic inc_c, inc_u;
      inc_c = 1'b0;
      inc_u = 1'b0;
      check("corr_cnt", corr_cnt, m_corr);
      check("uncorr_cnt", uncorr_cnt, m_uncorr);
      check("flags_exclusive", out_corr & out_uncorr, 0);
      if (stall_prev) begin
        check("hold_vld", out_vld, 1);
        check("hold_data", out_data, p_data);
        check("hold_flags", {out_corr, out_uncorr}, {p_corr, p_uncorr});
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_corr", out_corr, mon_e.corr);
          check("out_uncorr", out_uncorr, mon_e.uncorr);
          inc_c = mon_e.corr;
          inc_u = mon_e.uncorr;
        end
      end
      if (cnt_clr) begin
        m_corr   = 0;
        m_uncorr = 0;
      end else begin
        if (inc_c && m_corr < CMAX)     m_corr++;
        if (inc_u && m_uncorr < CMAX)   m_uncorr++;
      end
      stall_prev = out_vld && !out_rdy;
      p_data     = out_data;
      p_corr     = out_corr;
      p_uncorr   = out_uncorr;
    end
  end

  // Random back-pressure, active only while bp_en is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_rdy = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [DATA_W-1:0] w;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_corr, out_uncorr}, 0);
    check("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    check("rst_in_rdy", in_rdy, 1);

    // Clean word, including a check of the two-cycle latency.
    out_rdy = 1'b1;
    send(32'hDEADBEEF, '0, '0);
    check("latency_not_yet", out_vld, 0);
    @(posedge clk);
    #1;
    check("latency_2", out_vld, 1);
    check("clean_data", out_data, 32'hDEADBEEF);

    // Single data-bit error, then a flip of the overall parity bit alone.
    send(32'hDEADBEEF, TOT'(1) << 5, '0);
    send(32'hDEADBEEF, TOT'(1) << (TOT - 1), '0);
    // Double error on data bits 0 and 31.
    send(32'hDEADBEEF, (TOT'(1) << 31) | TOT'(1), '0);
    // Syndrome 63 (> N) with the overall check set is uncorrectable.
    e.data   = '0;
    e.corr   = 1'b0;
    e.uncorr = 1'b1;
    send_raw('0, 7'h7F, e, '0);
    drain();
    check("corr_cnt_2", corr_cnt, 2);
    check("uncorr_cnt_2", uncorr_cnt, 2);

    // Stall: three back-to-back words with out_rdy low.
    out_rdy = 1'b0;
    send($urandom, '0, '0);
    send($urandom, rand_flip(1), '0);
    fork
      send($urandom, rand_flip(2), '0);
      begin
        repeat (4) @(negedge clk);
        check("stall_in_rdy", in_rdy, 0);
        check("stall_out_vld", out_vld, 1);
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
    join
    drain();

    // Counter saturation, then a clear that coincides with a counted handshake.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) send($urandom, rand_flip(1), '0);
    drain();
    check("corr_cnt_sat", corr_cnt, CMAX);
    send($urandom, rand_flip(1), '0);
    for (int i = 0; i < 10 && !out_vld; i++) begin
      @(posedge clk);
      #1;
    end
    check("clr_sync_vld", out_vld, 1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr_wins", corr_cnt, 0);

    // Random traffic with random back-pressure.
    bp_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      send(w, rand_flip($urandom_range(2)), '0);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    drain();

`ifdef ECC_DEC_ERR_INJECT_EN
    // An injected single-bit error on a clean word is corrected.
    send(32'h1234_5678, '0, TOT'(1) << 3);
    drain();
`endif

    // Reset with two words in flight while the output is stalled.
    out_rdy = 1'b0;
    send($urandom, rand_flip(1), '0);
    send($urandom, rand_flip(2), '0);
    reset = 1'b1;
    @(negedge clk);
    check("in_rdy_during_reset", in_rdy, 1);
    @(posedge clk);
    #1;
    check("post_rst_vld", out_vld, 0);
    check("post_rst_data", out_data, 0);
    check("post_rst_flags", {out_corr, out_uncorr}, 0);
    check("post_rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    check("post_rst_in_rdy", in_rdy, 1);
    reset   = 1'b0;
    out_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_output", out_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
